// File: rtl/multibyte_add_sequencer_pkg.sv
// Shared constants and types for the byte-serial multi-precision add/subtract sequencer.
// Optional flag outputs are enabled by defining ADDSEQ_FLAGS_EN.
package addseq_pkg;

  localparam int BYTE_W     = 8;
  localparam int NBYTES_MIN = 1;
  localparam int NBYTES_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Byte counter width; a single-byte build still needs one bit.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/multibyte_add_sequencer_if.sv
// Request/response bundle between the ALU issue logic (master) and the add sequencer (slave).
// rsp_zero/rsp_ovf exist only when ADDSEQ_FLAGS_EN is defined.
interface multibyte_add_sequencer_if
  import addseq_pkg::*;
#(
  parameter int NBYTES = 4
);
  localparam int W = BYTE_W * NBYTES;

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         req_sub;
  logic         req_cin;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_cout;
`ifdef ADDSEQ_FLAGS_EN
  logic         rsp_zero;
  logic         rsp_ovf;
`endif

  modport master (
`ifdef ADDSEQ_FLAGS_EN
    input  rsp_zero, rsp_ovf,
`endif
    output req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout
  );

  modport slave (
`ifdef ADDSEQ_FLAGS_EN
    output rsp_zero, rsp_ovf,
`endif
    input  req_valid, req_a, req_b, req_sub, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/multibyte_add_sequencer_adder.sv
// Shared 8-bit adder with carry-in; carries are formed by full look-ahead over the byte.
module alt_carry_look_ahead_adder_cin_8
  import addseq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              cin_i,
  output logic [BYTE_W-1:0] sum_o,
  output logic              cout_o
);

  logic [BYTE_W-1:0] gen_d;
  logic [BYTE_W-1:0] prop_d;
  logic [BYTE_W:0]   carry_d;

  assign gen_d  = a_i & b_i;
  assign prop_d = a_i ^ b_i;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, with no ripple dependency on c[i]
  always_comb begin
    logic prop_run;
    carry_d    = '0;
    carry_d[0] = cin_i;
    prop_run   = 1'b0;
    for (int i = 0; i < BYTE_W; i++) begin
      carry_d[i+1] = gen_d[i];
      prop_run     = prop_d[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry_d[i+1] = carry_d[i+1] | (prop_run & gen_d[j]);
        prop_run     = prop_run & prop_d[j];
      end
      carry_d[i+1] = carry_d[i+1] | (prop_run & cin_i);
    end
  end

  assign sum_o  = prop_d ^ carry_d[BYTE_W-1:0];
  assign cout_o = carry_d[BYTE_W];

endmodule

// File: rtl/multibyte_add_sequencer.sv
// Byte-serial multi-precision add/subtract: one shared 8-bit adder stepped LSB byte first.
// Define ADDSEQ_FLAGS_EN to add the rsp_zero / rsp_ovf result flags.
module multibyte_add_sequencer
  import addseq_pkg::*;
#(
  parameter int NBYTES = 4
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  multibyte_add_sequencer_if.slave  bus
);

  localparam int              CNT_W = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
    $error("multibyte_add_sequencer: NBYTES out of range");
  end

  state_e                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic                            carry_q;
  logic [NBYTES-1:0][BYTE_W-1:0]   a_q;
  logic [NBYTES-1:0][BYTE_W-1:0]   b_q;
  logic [NBYTES-1:0][BYTE_W-1:0]   sum_q;
  logic                            cout_q;
  logic                            req_ready_q;
  logic                            rsp_valid_q;
`ifdef ADDSEQ_FLAGS_EN
  logic                            zero_q;
  logic                            ovf_q;
`endif

  logic [BYTE_W-1:0] a_byte_d;
  logic [BYTE_W-1:0] b_byte_d;
  logic [BYTE_W-1:0] s_byte_d;
  logic              c_out_d;

  assign a_byte_d = a_q[cnt_q];
  assign b_byte_d = b_q[cnt_q];

  alt_carry_look_ahead_adder_cin_8 u_adder (
    .a_i    (a_byte_d),
    .b_i    (b_byte_d),
    .cin_i  (carry_q),
    .sum_o  (s_byte_d),
    .cout_o (c_out_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
`ifdef ADDSEQ_FLAGS_EN
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            // Subtract is A + ~B + 1, so B is inverted once here and the carry seeded with 1
            a_q         <= bus.req_a;
            b_q         <= bus.req_sub ? ~bus.req_b : bus.req_b;
            carry_q     <= bus.req_sub ? 1'b1 : bus.req_cin;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            state_q     <= RUN;
`ifdef ADDSEQ_FLAGS_EN
            zero_q      <= 1'b1;
            ovf_q       <= 1'b0;
`endif
          end
        end
        RUN: begin
          sum_q[cnt_q] <= s_byte_d;
          carry_q      <= c_out_d;
          cnt_q        <= cnt_q + CNT_W'(1);
`ifdef ADDSEQ_FLAGS_EN
          zero_q       <= zero_q & (s_byte_d == '0);
`endif
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            cout_q      <= c_out_d;
            rsp_valid_q <= 1'b1;
            state_q     <= DONE;
`ifdef ADDSEQ_FLAGS_EN
            ovf_q       <= (a_byte_d[BYTE_W-1] ^ s_byte_d[BYTE_W-1]) &
                           (b_byte_d[BYTE_W-1] ^ s_byte_d[BYTE_W-1]);
`endif
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
`ifdef ADDSEQ_FLAGS_EN
  assign bus.rsp_zero  = zero_q;
  assign bus.rsp_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_multibyte_add_sequencer.sv
// Scoreboard bench for multibyte_add_sequencer: random and directed ops against a wide-arithmetic model.
// Flag checks are compiled in when ADDSEQ_FLAGS_EN is defined.
module tb_multibyte_add_sequencer;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multibyte_add_sequencer_if #(.NBYTES(NB)) bus ();
  multibyte_add_sequencer #(.NBYTES(NB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  multibyte_add_sequencer_if #(.NBYTES(1)) bus1 ();
  multibyte_add_sequencer #(.NBYTES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rmode = 0;  // 0: rsp_ready high, 1: random, 2: driven by the test sequence

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         zero;
    logic         ovf;
    int           acc;
  } exp_t;

  exp_t sbq[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s timed out (t=%0t)", nm, $time);
  endtask

  // Reference: whole-word arithmetic, signed overflow from an extended signed sum
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin, input int acc);
    exp_t              e;
    logic [W-1:0]      beff;
    logic              c;
    logic [W:0]        full;
    logic signed [W:0] t;
    beff   = sub ? ~b : b;
    c      = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, beff} + {{W{1'b0}}, c};
    t      = $signed({a[W-1], a}) + $signed({beff[W-1], beff}) + $signed({{W{1'b0}}, c});
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.zero = (full[W-1:0] == '0);
    e.ovf  = t[W] ^ t[W-1];
    e.acc  = acc;
    return e;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic cin, input bit hold);
    int n;
    int acc;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_sub   = sub;
    bus.req_cin   = cin;
    n = 0;
    while (!bus.req_ready) begin
      if (n >= 300) begin
        fail_now("req_accept");
        bus.req_valid = 1'b0;
        return;
      end
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    @(posedge clk);
    sbq.push_back(model(a, b, sub, cin, acc));
    #1;
    // Scramble the request after acceptance; the captured operands must not follow it
    bus.req_a   = $urandom;
    bus.req_b   = $urandom;
    bus.req_sub = 1'($urandom_range(0, 1));
    bus.req_cin = 1'($urandom_range(0, 1));
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) fail_now("drain");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return '1;
      2:       return {1'b0, {(W-1){1'b1}}};
      3:       return {1'b1, {(W-1){1'b0}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: compares every presented response with the scoreboard head
  bit first_seen = 1'b0;
  bit prev_v     = 1'b0;
  bit prev_hs    = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      first_seen = 1'b0;
      prev_v     = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      chk("req_ready_vs_busy", 128'(bus.req_ready), 128'(sbq.size() == 0));
      if (prev_v && !prev_hs) chk("rsp_valid_held", 128'(bus.rsp_valid), 128'(1));
      if (bus.rsp_valid) begin
        if (sbq.size() == 0) begin
          chk("spurious_rsp", 128'(bus.rsp_valid), 128'(0));
        end else begin
          chk("rsp_sum", 128'(bus.rsp_sum), 128'(sbq[0].sum));
          chk("rsp_cout", 128'(bus.rsp_cout), 128'(sbq[0].cout));
`ifdef ADDSEQ_FLAGS_EN
          chk("rsp_zero", 128'(bus.rsp_zero), 128'(sbq[0].zero));
          chk("rsp_ovf", 128'(bus.rsp_ovf), 128'(sbq[0].ovf));
`endif
          if (!first_seen) begin
            first_seen = 1'b1;
            chk("latency", 128'(cyc + 1 - sbq[0].acc), 128'(NB + 1));
          end
          if (bus.rsp_ready) begin
            void'(sbq.pop_front());
            first_seen = 1'b0;
          end
        end
      end
      prev_v  = bus.rsp_valid;
      prev_hs = bus.rsp_valid & bus.rsp_ready;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rmode == 0) bus.rsp_ready = 1'b1;
      else if (rmode == 1) bus.rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int acc;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_sub    = 1'b0;
    bus.req_cin    = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus1.req_valid = 1'b0;
    bus1.req_a     = '0;
    bus1.req_b     = '0;
    bus1.req_sub   = 1'b0;
    bus1.req_cin   = 1'b0;
    bus1.rsp_ready = 1'b1;

    #12;
    chk("reset_req_ready", 128'(bus.req_ready), 128'(1));
    chk("reset_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("reset_rsp_sum", 128'(bus.rsp_sum), 128'(0));
    chk("reset_rsp_cout", 128'(bus.rsp_cout), 128'(0));
`ifdef ADDSEQ_FLAGS_EN
    chk("reset_rsp_zero", 128'(bus.rsp_zero), 128'(0));
    chk("reset_rsp_ovf", 128'(bus.rsp_ovf), 128'(0));
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed cases: carry across byte, full wrap with cin, borrow (cin ignored), signed overflow
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    do_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0);
    do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 1'b0);
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    do_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0, 1'b1, 1'b0);
    drain();

    // Response backpressure: three DONE cycles without rsp_ready, handshake on the fourth
    rmode = 2;
    bus.rsp_ready = 1'b0;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rsp_valid) fail_now("done_wait");
    repeat (3) @(posedge clk);
    #2 bus.rsp_ready = 1'b1;
    drain();
    rmode = 0;

    // Reset in the middle of RUN (byte counter at 2)
    do_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrun_req_ready", 128'(bus.req_ready), 128'(1));
    chk("midrun_rsp_valid", 128'(bus.rsp_valid), 128'(0));
    chk("midrun_rsp_sum", 128'(bus.rsp_sum), 128'(0));
    chk("midrun_rsp_cout", 128'(bus.rsp_cout), 128'(0));
    sbq.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    do_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    drain();

    // Randomized traffic with random backpressure and random held-valid
    rmode = 1;
    for (int i = 0; i < 40; i++) begin
      do_op(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)));
    end
    bus.req_valid = 1'b0;
    drain();
    rmode = 0;

    // Single-byte build: 0xFF + 0x01
    @(negedge clk);
    bus1.req_valid = 1'b1;
    bus1.req_a     = 8'hFF;
    bus1.req_b     = 8'h01;
    bus1.req_sub   = 1'b0;
    bus1.req_cin   = 1'b0;
    chk("nb1_req_ready", 128'(bus1.req_ready), 128'(1));
    acc = cyc + 1;
    @(posedge clk);
    #1 bus1.req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus1.rsp_valid && n < 20);
    if (!bus1.rsp_valid) fail_now("nb1_rsp");
    else begin
      chk("nb1_latency", 128'(cyc + 1 - acc), 128'(2));
      chk("nb1_sum", 128'(bus1.rsp_sum), 128'(8'h00));
      chk("nb1_cout", 128'(bus1.rsp_cout), 128'(1));
`ifdef ADDSEQ_FLAGS_EN
      chk("nb1_zero", 128'(bus1.rsp_zero), 128'(1));
`endif
    end
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
